// File: rtl/it_pkg.sv
// Shared types and defaults for the IT feeder: data width, parameter defaults
// and the sequencing FSM state encoding.
package it_pkg;

  localparam int DATA_W      = 8;
  localparam int DEPTH_DEF   = 8;
  localparam int GAP_DEF     = 2;
  localparam int TIMEOUT_DEF = 255;
  localparam int WAIT_W      = 8;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/it_feeder_if.sv
// Link between the feeder and the IT block: Enter strobe plus byte going out,
// Halt plus result coming back.
interface it_feeder_if;
  import it_pkg::*;

  logic  enter;
  byte_t it_data;
  logic  halt;
  byte_t it_result;

  modport master (
    output enter,
    output it_data,
    input  halt,
    input  it_result
  );

  modport slave (
    input  enter,
    input  it_data,
    output halt,
    output it_result
  );

endinterface

// File: rtl/it_feed_fifo.sv
// Byte queue feeding the IT sequencer. Push beyond capacity and pop from empty
// are dropped; flush empties the queue in one cycle and wins over push/pop.
module it_feed_fifo
  import it_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  byte_t data_i,
  input  logic  pop_i,
  input  logic  flush_i,
  output logic  full_o,
  output logic  empty_o,
  output byte_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  byte_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign head_o  = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/it_feeder.sv
// Sends queued host bytes to the IT block one Enter strobe at a time and
// captures the IT result when Halt rises.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting loads, waiting for Start
// ST_SEND | Enter high for one cycle with the current byte
// ST_GAP  | Enter low for GAP cycles between bytes
// ST_WAIT | all bytes sent, counting cycles until Halt or timeout
module it_feeder
  import it_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  byte_t        load_data_i,
  input  logic         start_i,
  output logic         full_o,
  output logic         busy_o,
  output byte_t        result_o,
  output logic         done_o,
  output logic         early_o,
  output logic         timeout_o,
  it_feeder_if.master  it_bus
);

  state_e              state_q;
  logic [3:0]          gap_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                enter_q;
  logic                busy_q;
  logic                done_q;
  logic                early_q;
  logic                timeout_q;
  byte_t               it_data_q;
  byte_t               result_q;

  logic                fifo_full;
  logic                fifo_empty;
  byte_t               fifo_head;
  logic                idle;
  logic                load_ok;
  logic                start_ok;
  logic                bypass;
  logic                gap_done;
  logic                send_now;
  logic                halt_early;
  logic                fifo_push;
  logic                fifo_pop;

  assign idle       = (state_q == ST_IDLE);
  assign load_ok    = idle && load_i && !fifo_full;
  assign start_ok   = idle && start_i && (!fifo_empty || load_ok);
  // Load+Start into an empty queue: the new byte goes straight onto the bus.
  assign bypass     = start_ok && fifo_empty;
  assign gap_done   = (state_q == ST_GAP) && (gap_cnt_q == '0);
  assign halt_early = it_bus.halt && ((state_q == ST_SEND) || (state_q == ST_GAP));
  assign send_now   = start_ok || (gap_done && !it_bus.halt);
  assign fifo_push  = load_ok && !bypass;
  assign fifo_pop   = send_now && !fifo_empty;

  it_feed_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (load_data_i),
    .pop_i   (fifo_pop),
    .flush_i (halt_early),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      wait_cnt_q <= '0;
      enter_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      early_q    <= 1'b0;
      timeout_q  <= 1'b0;
      it_data_q  <= '0;
      result_q   <= '0;
    end else begin
      enter_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q   <= ST_SEND;
            busy_q    <= 1'b1;
            enter_q   <= 1'b1;
            it_data_q <= bypass ? load_data_i : fifo_head;
            done_q    <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
          end
        end

        ST_SEND: begin
          if (it_bus.halt) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            result_q <= it_bus.it_result;
            done_q   <= 1'b1;
            early_q  <= 1'b1;
          end else if (fifo_empty) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
          end else begin
            state_q   <= ST_GAP;
            gap_cnt_q <= 4'(GAP - 1);
          end
        end

        ST_GAP: begin
          if (it_bus.halt) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            result_q <= it_bus.it_result;
            done_q   <= 1'b1;
            early_q  <= 1'b1;
          end else if (gap_done) begin
            state_q   <= ST_SEND;
            enter_q   <= 1'b1;
            it_data_q <= fifo_head;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end

        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (it_bus.halt) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            result_q <= it_bus.it_result;
            done_q   <= 1'b1;
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            // Counter is about to reach TIMEOUT with no Halt seen.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign full_o         = fifo_full;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign done_o         = done_q;
  assign early_o        = early_q;
  assign timeout_o      = timeout_q;
  assign it_bus.enter   = enter_q;
  assign it_bus.it_data = it_data_q;

endmodule

// File: tb/tb_it_feeder.sv
// Randomized bench for it_feeder: a queue-and-arithmetic model predicts strobe
// timing, captured results and sticky flags for each Start sequence.
module tb_it_feeder;
  import it_pkg::*;

  localparam int DEPTH   = 8;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 255;
  localparam int STEP    = GAP + 1;

  logic  clk = 1'b0;
  logic  rst;
  logic  load;
  byte_t load_data;
  logic  start;
  logic  full;
  logic  busy;
  byte_t result;
  logic  done;
  logic  early;
  logic  tmo;

  it_feeder_if bus ();

  it_feeder #(
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (load_data),
    .start_i     (start),
    .full_o      (full),
    .busy_o      (busy),
    .result_o    (result),
    .done_o      (done),
    .early_o     (early),
    .timeout_o   (tmo),
    .it_bus      (bus)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  byte_t q_m[$];
  byte_t last_data_m;
  byte_t result_m;
  logic  done_m;
  logic  early_m;
  logic  tmo_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q_m.delete();
    last_data_m = '0;
    result_m    = '0;
    done_m      = 1'b0;
    early_m     = 1'b0;
    tmo_m       = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".full"},    full,        32'(q_m.size() == DEPTH));
    chk({tag, ".busy"},    busy,        0);
    chk({tag, ".enter"},   bus.enter,   0);
    chk({tag, ".itdata"},  bus.it_data, last_data_m);
    chk({tag, ".result"},  result,      result_m);
    chk({tag, ".done"},    done,        done_m);
    chk({tag, ".early"},   early,       early_m);
    chk({tag, ".timeout"}, tmo,         tmo_m);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0;
    bus.halt = 1'b0; bus.it_result = '0;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic load_list(input byte_t bl[$]);
    foreach (bl[i]) begin
      load = 1'b1;
      load_data = bl[i];
      tick();
      if (q_m.size() < DEPTH) q_m.push_back(bl[i]);
      chk("load.full", full, 32'(q_m.size() == DEPTH));
    end
    load = 1'b0;
  endtask

  task automatic load_random(input int n);
    byte_t bl[$];
    for (int i = 0; i < n; i++) bl.push_back(byte_t'($urandom));
    load_list(bl);
  endtask

  // mode: 0 halt while sending, 1 halt during wait, 2 no halt,
  //       3 halt on the last allowed wait cycle, 4 halt at cycle hfix
  task automatic run_seq(input int mode, input int hfix, input byte_t hval,
                         input bit extra_load, input byte_t extra_byte, input bit noise);
    byte_t sent[$];
    int    n, l_last, h, e_end;
    bit    halted, exp_en;
    start = 1'b1;
    if (extra_load) begin
      load = 1'b1;
      load_data = extra_byte;
      if (q_m.size() < DEPTH) q_m.push_back(extra_byte);
    end
    n = q_m.size();
    tick();
    start = 1'b0;
    load  = 1'b0;
    if (n == 0) begin
      chk("empty_start.busy", busy, 0);
      chk("empty_start.enter", bus.enter, 0);
      return;
    end
    sent = q_m;
    q_m.delete();
    done_m = 1'b0; early_m = 1'b0; tmo_m = 1'b0;
    l_last = 1 + (n - 1) * STEP;
    case (mode)
      0:       h = int'($urandom_range(l_last, 1));
      1:       h = l_last + int'($urandom_range(20, 1));
      2:       h = -1;
      3:       h = l_last + TIMEOUT;
      default: h = hfix;
    endcase
    halted = (h >= 1) && (h <= l_last + TIMEOUT);
    e_end  = halted ? h + 1 : l_last + TIMEOUT + 1;
    for (int c = 1; c < e_end; c++) begin
      exp_en = ((c - 1) % STEP == 0) && ((c - 1) / STEP < n);
      if (exp_en) last_data_m = sent[(c-1)/STEP];
      chk("seq.enter", bus.enter, 32'(exp_en));
      chk("seq.itdata", bus.it_data, last_data_m);
      chk("seq.busy", busy, 1);
      bus.halt      = (c == h);
      bus.it_result = (c == h) ? hval : byte_t'($urandom);
      if (noise) begin
        load      = ($urandom % 4) == 0;
        load_data = byte_t'($urandom);
        start     = ($urandom % 4) == 0;
      end
      tick();
    end
    bus.halt = 1'b0; load = 1'b0; start = 1'b0;
    if (halted) begin
      result_m = hval;
      done_m   = 1'b1;
      early_m  = (h <= l_last);
    end else begin
      tmo_m = 1'b1;
    end
    chk_idle("seq.end");
  endtask

  initial begin
    byte_t bl[$];
    do_reset();
    chk_idle("reset");

    // Three bytes, Halt three cycles after the last strobe.
    bl = '{8'h11, 8'h22, 8'h33};
    load_list(bl);
    run_seq(4, 10, 8'hA5, 1'b0, 8'h00, 1'b0);

    // Nine loads into an 8-deep queue: the last one is dropped.
    load_random(9);
    chk("overfill.size", 32'(q_m.size()), DEPTH);
    run_seq(1, 0, byte_t'($urandom), 1'b0, 8'h00, 1'b0);

    // Single byte, Halt never comes.
    load_random(1);
    run_seq(2, 0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Halt in the gap after byte 2 of 4 flushes the rest.
    load_random(4);
    run_seq(4, 5, 8'h5C, 1'b0, 8'h00, 1'b0);
    tick();
    chk_idle("early.after");
    run_seq(1, 0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Halt on the final wait cycle still counts as Done.
    load_random(2);
    run_seq(3, 0, 8'hC3, 1'b0, 8'h00, 1'b0);

    // Load and Start together into an empty queue.
    run_seq(1, 0, 8'h3E, 1'b1, 8'h77, 1'b0);

    // Halt in IDLE is ignored.
    bus.halt = 1'b1; bus.it_result = 8'hEE;
    tick();
    bus.halt = 1'b0;
    tick();
    chk_idle("idle_halt");

    // Reset in the first gap of a three-byte sequence.
    load_random(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_mid.enter", bus.enter, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk_idle("rst_mid");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_mid.start_busy", busy, 0);
    tick();
    chk_idle("rst_mid.after");

    for (int it = 0; it < 30; it++) begin
      int mode;
      int r;
      load_random(int'($urandom_range(10, 0)));
      r = int'($urandom_range(19, 0));
      mode = (r < 9) ? 0 : (r < 16) ? 1 : (r < 18) ? 3 : 2;
      run_seq(mode, 0, byte_t'($urandom), 1'($urandom), byte_t'($urandom), 1'b1);
      repeat (int'($urandom_range(3, 0))) tick();
      chk_idle("rand.idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
